fifo_ram_ctrl: RTL and testbench
================================

// Module: fifo_ram_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives DUAL_PORT_RAM: port 0 as write, port 1 as read.
//  Valid/ready handshakes on the push and pop sides; pointers and occupancy; one-entry output register.
//  Sits between a producer/consumer pair and the RAM instance in the FIFO top level.
// PARAMETERS
//  DATA_WIDTH   8  word width; equals the RAM DATA_RAM_WIDTH
//  ADDR_WIDTH   8  RAM address width; DEPTH = 2**ADDR_WIDTH words total capacity
//  AF_LEVEL     DEPTH-2  almost_full asserts when count >= AF_LEVEL
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           synchronous active-low reset
//  flush        in   1           synchronous clear of all contents, active-high
//  wr_valid     in   1           producer offers wr_data
//  wr_ready     out  1           controller accepts; push = wr_valid && wr_ready
//  wr_data      in   DATA_WIDTH  word to push
//  rd_valid     out  1           rd_data holds the oldest word
//  rd_ready     in   1           consumer takes; pop = rd_valid && rd_ready
//  rd_data      out  DATA_WIDTH  registered head word
//  count        out  ADDR_WIDTH+1  words held: RAM entries plus output register
//  full         out  1           count == DEPTH
//  empty        out  1           count == 0
//  almost_full  out  1           count >= AF_LEVEL
//  ram_addr_0   out  ADDR_WIDTH  RAM write address = wr_ptr[ADDR_WIDTH-1:0]
//  ram_ce_0     out  1           high only in a push cycle
//  ram_wr_0     out  1           high only in a push cycle
//  ram_data_0   out  DATA_WIDTH  = wr_data
//  ram_addr_1   out  ADDR_WIDTH  RAM read address = rd_ptr[ADDR_WIDTH-1:0]
//  ram_ce_1     out  1           constant 1
//  ram_wr_1     out  1           constant 0
//  ram_data_1   in   DATA_WIDTH  RAM read data; combinational from ram_addr_1
// BEHAVIOUR
//  Reset (rst_n=0 at edge) and flush (flush=1 at edge) have the same effect:
//   wr_ptr=rd_ptr=0, count=0, rd_valid=0, rd_data=0, state=OUT_EMPTY.
//   Reset takes priority over flush; flush takes priority over push and pop in the same cycle.
//  Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. Low bits address the RAM; the MSB is
//   the wrap bit. Both increment modulo 2**(ADDR_WIDTH+1).
//  ram_used = wr_ptr - rd_ptr, computed from registered pointers only.
//  Push side:
//   wr_ready = !full, decoded from registered count; no fall-through of a same-cycle pop.
//   A push drives ram_ce_0 = ram_wr_0 = 1 combinationally; wr_ptr++ at the edge.
//   wr_valid while full: ignored, no RAM write, pointers unchanged.
//  Output stage, 2-state FSM:
//   OUT_EMPTY: if ram_used != 0 -> load rd_data <= ram_data_1, rd_ptr++, go OUT_VALID.
//   OUT_VALID: rd_valid=1.
//    - pop and ram_used != 0: reload rd_data, rd_ptr++, stay in OUT_VALID.
//    - pop and ram_used == 0: go OUT_EMPTY.
//    - no pop: hold rd_data.
//  A word written at edge N becomes ram-visible at N+1. Minimum push-to-rd_valid latency is
//   2 edges: pushed at N, loaded at N+1, rd_valid high after N+1.
//  count: +1 on push only, -1 on pop only, unchanged on push+pop. Never exceeds DEPTH or goes
//   below 0.
//  Simultaneous push and pop when full: the pop proceeds, the push is refused (wr_ready=0).
//   wr_ready rises the next cycle.
//  rd_data is stable while rd_valid && !rd_ready. rd_valid never drops without a pop, flush
//   or reset.
//  All flags are decoded from registered count: empty = (count==0), full = (count==DEPTH).
// TESTING
//  Reset: drive rst_n=0 for 2 cycles -> count=0, empty=1, full=0, rd_valid=0, wr_ready=1,
//   rd_data=0.
//  Single word: push 0xA5 at edge 1 -> rd_valid=1 and rd_data=0xA5 after edge 2; pop ->
//   empty=1.
//  Fill (ADDR_WIDTH=3): push 0..7 with rd_ready=0 -> full=1 and wr_ready=0; a 9th push is
//   ignored; drain yields 0..7 in order.
//  Wrap: 20 push/pop pairs with random stalls at ADDR_WIDTH=3 -> in-order data; count tracks
//   a reference model each cycle.
//  Full+pop: at count=8, push+pop in the same cycle -> count=7; the push is refused; the next
//   push is accepted.
//  Flush mid-stream: 5 words held, flush=1 with wr_valid=1 -> next cycle count=0, rd_valid=0,
//   no RAM write.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ram_ctrl
// Synchronous FIFO controller for an external dual-port RAM.
// RAM port 0 is used only for writes and port 1 only for reads. The oldest
// word is kept in a one-entry output register, so the total capacity is
// 2**ADDR_WIDTH words: RAM entries plus the output register.
//
// Ports
//   clk, rst_n         single clock; synchronous active-low reset
//   flush              synchronous clear of all contents (active-high)
//   wr_valid/wr_ready  push handshake, wr_data is the pushed word
//   rd_valid/rd_ready  pop handshake, rd_data is the registered head word
//   count              words held (RAM entries plus output register)
//   full/empty         count == DEPTH / count == 0
//   almost_full        count >= AF_LEVEL
//   ram_*_0            RAM write port (address, chip enable, write, data)
//   ram_*_1            RAM read port; ram_data_1 is combinational from ram_addr_1
// ---------------------------------------------------------------------------
module fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic                  ram_ce_0,
  output logic                  ram_wr_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  output logic                  ram_ce_1,
  output logic                  ram_wr_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  out_state_t state, state_next;

  // Pointers carry an extra wrap bit so that wr_ptr - rd_ptr spans 0..DEPTH.
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] ram_used;
  logic                push, pop, load;

  assign ram_used = wr_ptr - rd_ptr;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (int'(count) >= AF_LEVEL);
  assign wr_ready    = !full;
  assign rd_valid    = (state == OUT_VALID);

  // Reset and flush override the handshakes, so no RAM write is issued in
  // a flush cycle even if the producer is offering data.
  assign push = wr_valid && wr_ready && rst_n && !flush;
  assign pop  = rd_valid && rd_ready && rst_n && !flush;

  assign ram_addr_0 = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_ce_0   = push;
  assign ram_wr_0   = push;
  assign ram_data_0 = wr_data;
  assign ram_addr_1 = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_ce_1   = 1'b1;
  assign ram_wr_1   = 1'b0;

  // Output stage: decide when the head register is (re)loaded from RAM.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (ram_used != '0) begin
          load       = 1'b1;
          state_next = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (pop) begin
          if (ram_used != '0) begin
            load = 1'b1;
          end else begin
            state_next = OUT_EMPTY;
          end
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (load) begin
        rd_ptr  <= rd_ptr + ONE_C;
        rd_data <= ram_data_1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ram_ctrl
// Bench for fifo_ram_ctrl at ADDR_WIDTH=3. Holds a RAM model on the RAM
// ports and a queue-based reference of the FIFO contents.
// ---------------------------------------------------------------------------
module tb_fifo_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full, empty, almost_full;
  logic [AW-1:0] ram_addr_0, ram_addr_1;
  logic          ram_ce_0, ram_wr_0, ram_ce_1, ram_wr_1;
  logic [DW-1:0] ram_data_0, ram_data_1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce_0 && ram_wr_0) mem[ram_addr_0] <= ram_data_0;
  end
  assign ram_data_1 = mem[ram_addr_1];

  fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ram_addr_0(ram_addr_0), .ram_ce_0(ram_ce_0), .ram_wr_0(ram_wr_0),
    .ram_data_0(ram_data_0), .ram_addr_1(ram_addr_1), .ram_ce_1(ram_ce_1),
    .ram_wr_1(ram_wr_1), .ram_data_1(ram_data_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference,
  // then advance the reference by the handshakes of this cycle.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    logic exp_push, do_pop;
    int   n;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    n = q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
    chk("wr_ready", 32'(wr_ready), 32'(n < DEPTH));
    if (n == 0) chk("rd_valid_when_empty", 32'(rd_valid), 0);
    if (rd_valid && n > 0) chk("rd_data_head", 32'(rd_data), 32'(q[0]));
    exp_push = wv && !fl && (n < DEPTH);
    chk("ram_ce_0", 32'(ram_ce_0), 32'(exp_push));
    chk("ram_wr_1", 32'(ram_wr_1), 0);
    do_pop = rd_valid && rr && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (exp_push) q.push_back(wd);
    end
    @(negedge clk);
    $display("[TB] t=%0t wv=%0b wd=%02h rr=%0b fl=%0b push=%0b pop=%0b ref_count=%0d",
             $time, wv, wd, rr, fl, exp_push, do_pop, q.size());
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 32'(q.size()), 0);
  endtask

  initial begin
    // Reset for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_data", 32'(rd_data), 0);
    @(negedge clk);

    // Single word: two-edge latency to rd_valid.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_edge1_rd_valid", 32'(rd_valid), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_edge2_rd_valid", 32'(rd_valid), 1);
    chk("lat_edge2_rd_data", 32'(rd_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", 32'(empty), 1);

    // Fill to capacity, try one extra push, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_wr_ready", 32'(wr_ready), 0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("fill_extra_count", 32'(count), DEPTH);
    drain();

    // Push+pop while full: pop proceeds, push refused, next push accepted.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), DEPTH - 1);
    chk("fullpop_wr_ready", 32'(wr_ready), 1);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    chk("fullpop_next_push", 32'(count), DEPTH);
    drain();

    // Randomised traffic with stalls across several pointer wraps.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Flush with five words held and a push offered.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("preflush_count", 32'(count), 5);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_empty", 32'(empty), 1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("postflush_rd_data", 32'(rd_data), 32'h3C);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
